weighted_rr_arbiter: RTL

//  Weighted, transaction-locking round-robin arbiter for shared resources (bus ports, CDB, mem req).

---
 rtl/arbiter_pkg.sv | 17 +
 rtl/weighted_rr_arbiter_rr_pick.sv | 45 ++++
 rtl/weighted_rr_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter_pkg
// Shared types and defaults for the weighted round-robin arbiter.
//   arb_state_e : two-state arbiter FSM encoding (idle / grant held)
//   ARB_NUM_REQ_DEFAULT, ARB_WEIGHT_W_DEFAULT : default parameter values
// -----------------------------------------------------------------------------
package arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_NUM_REQ_DEFAULT  = 4;
    localparam int ARB_WEIGHT_W_DEFAULT = 4;

endpackage

// File: rtl/weighted_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational find-first-set starting at a rotating index, wrapping modulo N.
//   req   : request vector
//   start : index searched first (must be < N)
//   valid : at least one request present
//   idx   : first set request at start, start+1, ... (mod N); 0 when none
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  hit;
    logic [IW-1:0] cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            // start + offset can exceed N-1; an explicit compare keeps the wrap
            // correct for non-power-of-two N.
            logic [IW:0] sum;
            assign sum       = {1'b0, start} + (IW+1)'(gi);
            assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    // Scan from the farthest offset back to offset 0 so the nearest hit wins.
    always_comb begin
        valid = |hit;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// -----------------------------------------------------------------------------
// weighted_rr_arbiter
// Weighted, transaction-locking round-robin arbiter. One requester is granted
// per transaction; the grant is held until the owner asserts last_i. A
// requester with weight w may win w+1 consecutive transactions before
// priority rotates past it.
//
// Ports
//   clk_i     : clock
//   arst_i    : asynchronous reset, active-high
//   allow_i   : a new arbitration may take place this cycle
//   req_i     : request vector
//   weight_i  : per-requester weight, [NUM_REQ-1:0][WEIGHT_W-1:0]
//   last_i    : owner's final cycle of the current transaction
//   gnt_o     : one-hot registered grant
//   gnt_idx_o : index of the granted requester (0 when idle)
//   busy_o    : a grant is held
//
// Optional feature (macro WRR_ABORT_EN): while a grant is held, the owner
// dropping its request ends the transaction as if last_i were asserted with
// its credit exhausted. Without the macro, req_i is ignored while busy.
// -----------------------------------------------------------------------------
module weighted_rr_arbiter
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ  = ARB_NUM_REQ_DEFAULT,
    parameter int WEIGHT_W = ARB_WEIGHT_W_DEFAULT,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                               clk_i,
    input  logic                               arst_i,
    input  logic                               allow_i,
    input  logic [NUM_REQ-1:0]                 req_i,
    input  logic [NUM_REQ-1:0][WEIGHT_W-1:0]   weight_i,
    input  logic                               last_i,
    output logic [NUM_REQ-1:0]                 gnt_o,
    output logic [IDX_W-1:0]                   gnt_idx_o,
    output logic                               busy_o
);

    arb_state_e          state_reg,   state_next;
    logic [IDX_W-1:0]    rot_ptr_reg, rot_ptr_next;
    logic [WEIGHT_W-1:0] credit_reg,  credit_next;
    logic                fresh_reg,   fresh_next;
    logic [NUM_REQ-1:0]  gnt_reg,     gnt_next;
    logic [IDX_W-1:0]    gnt_idx_reg, gnt_idx_next;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic                abort;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req   (req_i),
        .start (rot_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef WRR_ABORT_EN
    // Owner withdrew its request: treat as an early, credit-exhausting finish.
    assign abort = (state_reg == ARB_BUSY) && !req_i[gnt_idx_reg];
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        rot_ptr_next = rot_ptr_reg;
        credit_next  = credit_reg;
        fresh_next   = fresh_reg;
        gnt_next     = gnt_reg;
        gnt_idx_next = gnt_idx_reg;

        case (state_reg)
            ARB_IDLE: begin
                if (allow_i && pick_valid) begin
                    state_next   = ARB_BUSY;
                    gnt_next     = NUM_REQ'(1) << pick_idx;
                    gnt_idx_next = pick_idx;
                    // A new turn starts when the previous turn ended or when the
                    // pointer holder was skipped; only then is the weight sampled.
                    if (fresh_reg || (pick_idx != rot_ptr_reg)) begin
                        credit_next  = weight_i[pick_idx];
                        fresh_next   = 1'b0;
                        rot_ptr_next = pick_idx;
                    end
                end
            end
            ARB_BUSY: begin
                if (last_i || abort) begin
                    state_next   = ARB_IDLE;
                    gnt_next     = '0;
                    gnt_idx_next = '0;
                    if ((credit_reg == '0) || abort) begin
                        rot_ptr_next = (gnt_idx_reg == IDX_W'(NUM_REQ - 1))
                                       ? '0 : gnt_idx_reg + IDX_W'(1);
                        fresh_next   = 1'b1;
                    end else begin
                        credit_next  = credit_reg - WEIGHT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg   <= ARB_IDLE;
            rot_ptr_reg <= '0;
            credit_reg  <= '0;
            fresh_reg   <= 1'b1;
            gnt_reg     <= '0;
            gnt_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rot_ptr_reg <= rot_ptr_next;
            credit_reg  <= credit_next;
            fresh_reg   <= fresh_next;
            gnt_reg     <= gnt_next;
            gnt_idx_reg <= gnt_idx_next;
        end
    end

    assign busy_o    = (state_reg == ARB_BUSY);
    assign gnt_o     = gnt_reg;
    assign gnt_idx_o = gnt_idx_reg;

endmodule
